// File: rtl/set_clr_pkg.sv
// Shared encodings for the set-enable clear controller: channel FSM states,
// clear-mode codes and the channel-count limit.
package set_clr_pkg;

  localparam int MAX_CH = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_HOLD   = 2'd2
  } ch_state_e;

  typedef enum logic [1:0] {
    MODE_LEVEL  = 2'b00,
    MODE_PULSE  = 2'b01,
    MODE_STICKY = 2'b10,
    MODE_RSVD   = 2'b11
  } clr_mode_e;

endpackage

// File: rtl/set_clr_ch.sv
// One clear channel: flag edge detect, IDLE/ACTIVE/HOLD clear FSM and a
// saturating event counter. Clr is active-low and registered.
module set_clr_ch
  import set_clr_pkg::*;
#(
  parameter int PULSE_W = 4,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [1:0]         mode,
  input  logic [PULSE_W-1:0] pulse_len,
  input  logic               full,
  input  logic               rls,
  input  logic               cnt_clr,
  output logic               clr,
  output logic               busy,
  output logic [CNT_W-1:0]   evt_cnt
);

  logic               full_p1;
  logic               rise;
  ch_state_e          state_q, state_n;
  clr_mode_e          mode_q, mode_n;
  logic [PULSE_W-1:0] pcnt_q, pcnt_n;
  logic               clr_q, clr_n;
  logic [CNT_W-1:0]   cnt_q, cnt_n;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [PULSE_W-1:0] pulse_load(input logic [PULSE_W-1:0] len);
    return (len == '0) ? PULSE_W'(1) : len;
  endfunction

  assign rise = full & ~full_p1;

  always_comb begin
    state_n = state_q;
    mode_n  = mode_q;
    pcnt_n  = pcnt_q;
    clr_n   = 1'b1;
    cnt_n   = cnt_q;

    if (cnt_clr)
      cnt_n = '0;
    else if (enable && rise)
      cnt_n = sat_inc(cnt_q);

    if (!enable) begin
      state_n = ST_IDLE;
      pcnt_n  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          case (clr_mode_e'(mode))
            MODE_PULSE: begin
              if (rise) begin
                state_n = ST_ACTIVE;
                mode_n  = MODE_PULSE;
                pcnt_n  = pulse_load(pulse_len);
                clr_n   = 1'b0;
              end
            end
            MODE_STICKY: begin
              if (rise) begin
                state_n = ST_HOLD;
                mode_n  = MODE_STICKY;
                clr_n   = 1'b0;
              end
            end
            default: clr_n = ~full;
          endcase
        end
        // pcnt_q counts the clear cycles still owed, including the current one
        ST_ACTIVE: begin
          if (pcnt_q <= PULSE_W'(1) || mode_q != MODE_PULSE) begin
            state_n = ST_IDLE;
            pcnt_n  = '0;
          end else begin
            pcnt_n = pcnt_q - 1'b1;
            clr_n  = 1'b0;
          end
        end
        ST_HOLD: begin
          if (rls || mode_q != MODE_STICKY)
            state_n = ST_IDLE;
          else
            clr_n = 1'b0;
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_p1 <= 1'b0;
      state_q <= ST_IDLE;
      mode_q  <= MODE_LEVEL;
      pcnt_q  <= '0;
      clr_q   <= 1'b1;
      cnt_q   <= '0;
    end else begin
      full_p1 <= full;
      state_q <= state_n;
      mode_q  <= mode_n;
      pcnt_q  <= pcnt_n;
      clr_q   <= clr_n;
      cnt_q   <= cnt_n;
    end
  end

  assign clr     = clr_q;
  assign busy    = (state_q != ST_IDLE);
  assign evt_cnt = cnt_q;

endmodule

// File: rtl/set_clr_ctrl.sv
// Multi-channel set-enable clear controller: NUM_CH independent clear
// channels plus the any-clear reduction and event-counter packing.
module set_clr_ctrl
  import set_clr_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int PULSE_W = 4,
  parameter int CNT_W   = 8
) (
  input  logic                    SET_CLR_CTRL_Clk,
  input  logic                    SET_CLR_CTRL_Reset,
  input  logic                    SET_CLR_CTRL_Enable,
  input  logic [1:0]              SET_CLR_CTRL_Mode,
  input  logic [PULSE_W-1:0]      SET_CLR_CTRL_Pulse_Len,
  input  logic [NUM_CH-1:0]       SET_CLR_CTRL_Flag_Om_Full,
  input  logic [NUM_CH-1:0]       SET_CLR_CTRL_Release,
  input  logic                    SET_CLR_CTRL_Cnt_Clr,
  output logic [NUM_CH-1:0]       SET_CLR_CTRL_Clr,
  output logic [NUM_CH-1:0]       SET_CLR_CTRL_Busy,
  output logic                    SET_CLR_CTRL_Any_Clr,
  output logic [NUM_CH*CNT_W-1:0] SET_CLR_CTRL_Evt_Cnt
);

  if (NUM_CH < 1 || NUM_CH > MAX_CH) begin : g_bad_num_ch
    $error("set_clr_ctrl: NUM_CH out of range");
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    set_clr_ch #(
      .PULSE_W (PULSE_W),
      .CNT_W   (CNT_W)
    ) u_ch (
      .clk       (SET_CLR_CTRL_Clk),
      .rst       (SET_CLR_CTRL_Reset),
      .enable    (SET_CLR_CTRL_Enable),
      .mode      (SET_CLR_CTRL_Mode),
      .pulse_len (SET_CLR_CTRL_Pulse_Len),
      .full      (SET_CLR_CTRL_Flag_Om_Full[i]),
      .rls       (SET_CLR_CTRL_Release[i]),
      .cnt_clr   (SET_CLR_CTRL_Cnt_Clr),
      .clr       (SET_CLR_CTRL_Clr[i]),
      .busy      (SET_CLR_CTRL_Busy[i]),
      .evt_cnt   (SET_CLR_CTRL_Evt_Cnt[i*CNT_W +: CNT_W])
    );
  end

  // Clr bits are registered, so this reduction has no input-to-output path
  assign SET_CLR_CTRL_Any_Clr = ~&SET_CLR_CTRL_Clr;

endmodule

// File: tb/tb_set_clr_ctrl.sv
// Bench for set_clr_ctrl: directed scenarios plus random stimulus, checked
// every cycle against a timestamp-based reference model.
module tb_set_clr_ctrl;
  localparam int NUM_CH  = 4;
  localparam int PULSE_W = 4;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    rst, en, cclr;
  logic [1:0]              mode;
  logic [PULSE_W-1:0]      plen;
  logic [NUM_CH-1:0]       full, rel;
  logic [NUM_CH-1:0]       clr, busy;
  logic                    any;
  logic [NUM_CH*CNT_W-1:0] evt;

  set_clr_ctrl #(.NUM_CH(NUM_CH), .PULSE_W(PULSE_W), .CNT_W(CNT_W)) dut (
    .SET_CLR_CTRL_Clk          (clk),
    .SET_CLR_CTRL_Reset        (rst),
    .SET_CLR_CTRL_Enable       (en),
    .SET_CLR_CTRL_Mode         (mode),
    .SET_CLR_CTRL_Pulse_Len    (plen),
    .SET_CLR_CTRL_Flag_Om_Full (full),
    .SET_CLR_CTRL_Release      (rel),
    .SET_CLR_CTRL_Cnt_Clr      (cclr),
    .SET_CLR_CTRL_Clr          (clr),
    .SET_CLR_CTRL_Busy         (busy),
    .SET_CLR_CTRL_Any_Clr      (any),
    .SET_CLR_CTRL_Evt_Cnt      (evt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model: a pulse is a clear window ending at cycle m_end,
  // a sticky clear is a flag; the model keeps its own flag history.
  int cyc = 0;
  bit m_prev [NUM_CH];
  int m_end  [NUM_CH];
  bit m_stk  [NUM_CH];
  int m_cnt  [NUM_CH];
  bit e_clr  [NUM_CH];
  bit e_busy [NUM_CH];

  task automatic model_step();
    bit rise, was_busy, lvl;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rst) begin
        m_prev[i] = 1'b0; m_end[i] = -1; m_stk[i] = 1'b0;
        m_cnt[i] = 0; e_clr[i] = 1'b1; e_busy[i] = 1'b0;
      end else begin
        rise      = full[i] && !m_prev[i];
        m_prev[i] = full[i];
        was_busy  = m_stk[i] || (cyc <= m_end[i]);
        if (cclr) m_cnt[i] = 0;
        else if (en && rise && m_cnt[i] < CNT_MAX) m_cnt[i] = m_cnt[i] + 1;
        if (!en) begin
          m_end[i] = -1; m_stk[i] = 1'b0; e_clr[i] = 1'b1; e_busy[i] = 1'b0;
        end else begin
          lvl = 1'b1;
          if (m_stk[i]) begin
            if (rel[i]) m_stk[i] = 1'b0;
          end else if (!was_busy) begin
            case (mode)
              2'b01: if (rise) m_end[i] = cyc + ((plen == 0) ? 1 : int'(plen));
              2'b10: if (rise) m_stk[i] = 1'b1;
              default: lvl = !full[i];
            endcase
          end
          e_busy[i] = m_stk[i] || (cyc + 1 <= m_end[i]);
          e_clr[i]  = e_busy[i] ? 1'b0 : lvl;
        end
      end
    end
    cyc++;
  endtask

  task automatic check_all();
    logic [NUM_CH-1:0]       ec, eb;
    logic [NUM_CH*CNT_W-1:0] ee;
    for (int i = 0; i < NUM_CH; i++) begin
      ec[i] = e_clr[i];
      eb[i] = e_busy[i];
      ee[i*CNT_W +: CNT_W] = CNT_W'(m_cnt[i]);
    end
    check_eq("clr", 32'(clr), 32'(ec));
    check_eq("busy", 32'(busy), 32'(eb));
    check_eq("any_clr", 32'(any), 32'(~&ec));
    check_eq("evt_cnt", 32'(evt), 32'(ee));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b1; full = '0; rel = '0; cclr = 1'b0; en = 1'b1;
    tick();
    check_eq("rst_clr", 32'(clr), 32'hF);
    check_eq("rst_busy", 32'(busy), 32'h0);
    check_eq("rst_any", 32'(any), 32'h0);
    check_eq("rst_evt", 32'(evt), 32'h0);
    rst = 1'b0;
  endtask

  initial begin
    int lows, blows;
    rst = 1'b1; en = 1'b0; cclr = 1'b0; mode = 2'b00; plen = '0; full = '0; rel = '0;
    do_reset();

    // level mode
    mode = 2'b00; lows = 0;
    for (int k = 0; k < 12; k++) begin
      full[0] = (k >= 3 && k < 8);
      tick();
      if (!clr[0]) lows++;
    end
    check_eq("lvl_lows", 32'(lows), 32'd5);
    check_eq("lvl_cnt", 32'(evt[1:0]), 32'd1);

    // pulse mode with re-toggles during the pulse, then zero length
    do_reset();
    mode = 2'b01; plen = 4'd3; lows = 0; blows = 0;
    for (int k = 0; k < 14; k++) begin
      full[1] = (k == 3) || (k >= 5 && k < 9);
      tick();
      if (!clr[1]) lows++;
      if (busy[1]) blows++;
    end
    check_eq("pls_lows", 32'(lows), 32'd3);
    check_eq("pls_busy", 32'(blows), 32'd3);
    check_eq("pls_cnt", 32'(evt[3:2]), 32'd2);
    plen = 4'd0; lows = 0;
    for (int k = 0; k < 10; k++) begin
      full[1] = (k >= 2 && k < 6);
      tick();
      if (!clr[1]) lows++;
    end
    check_eq("pls0_lows", 32'(lows), 32'd1);

    // sticky mode, with a release while idle that must be ignored
    do_reset();
    mode = 2'b10; lows = 0;
    for (int k = 0; k < 20; k++) begin
      full[2] = (k >= 4);
      rel[2]  = (k == 1) || (k == 13);
      tick();
      if (!clr[2]) lows++;
    end
    rel = '0;
    check_eq("stk_lows", 32'(lows), 32'd9);

    // counter saturation and clear racing an edge
    do_reset();
    mode = 2'b00;
    for (int k = 0; k < 10; k++) begin
      full[3] = (k % 2 == 1);
      tick();
    end
    check_eq("sat_cnt", 32'(evt[7:6]), 32'd3);
    full[3] = 1'b0; tick();
    full[3] = 1'b1; cclr = 1'b1; tick();
    cclr = 1'b0;
    check_eq("cclr_cnt", 32'(evt[7:6]), 32'd0);
    tick();
    check_eq("cclr_hold", 32'(evt[7:6]), 32'd0);

    // reset mid-pulse, flag high straight after reset, enable drop in hold
    do_reset();
    mode = 2'b01; plen = 4'd10;
    tick();
    full[1] = 1'b1; tick(); tick();
    rst = 1'b1; tick();
    check_eq("abort_clr", 32'(clr), 32'hF);
    check_eq("abort_busy", 32'(busy), 32'h0);
    rst = 1'b0; mode = 2'b10; tick();
    check_eq("post_rst_edge", 32'(busy[1]), 32'd1);
    full[2] = 1'b1; tick(); tick();
    en = 1'b0; tick();
    check_eq("dis_clr", 32'(clr), 32'hF);
    check_eq("dis_busy", 32'(busy), 32'h0);
    en = 1'b1; tick();
    check_eq("reen_busy", 32'(busy), 32'h0);

    // random traffic
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      full = full ^ (NUM_CH'($urandom) & NUM_CH'($urandom));
      rel  = NUM_CH'($urandom) & NUM_CH'($urandom) & NUM_CH'($urandom);
      if ($urandom_range(0, 19) == 0) mode = 2'($urandom);
      if ($urandom_range(0, 9) == 0) plen = PULSE_W'($urandom);
      en   = ($urandom_range(0, 29) != 0);
      cclr = ($urandom_range(0, 49) == 0);
      rst  = ($urandom_range(0, 199) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
